// File: rtl/alu_n_seq.sv
// Registered N-bit ALU with valid/ready input handshake, persistent c/n/z/v flags
// and an iterative shift-add multiplier that completes WIDTH cycles after accept.
module alu_n_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  typedef enum logic [3:0] {
    OP_NOTA = 4'h0, OP_NOTB = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_XOR  = 4'h4, OP_XNOR = 4'h5, OP_ADD  = 4'h6, OP_SUB  = 4'h7,
    OP_ADC  = 4'h8, OP_SBC  = 4'h9, OP_SHL  = 4'hA, OP_SHR  = 4'hB,
    OP_ASR  = 4'hC, OP_MUL  = 4'hD, OP_PASS = 4'hE, OP_RSVD = 4'hF
  } op_e;

  typedef enum logic {IDLE, MUL} state_e;

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e state, state_d;

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] opb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             carry_msb;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op_e'(op) == OP_MUL);

  // One adder serves ADD/SUB/ADC/SBC; SUB-type ops invert B and take the carry-in.
  assign opb       = (op_e'(op) == OP_SUB || op_e'(op) == OP_SBC) ? ~b : b;
  assign cin       = (op_e'(op) == OP_SUB) ? 1'b1 :
                     (op_e'(op) == OP_ADC || op_e'(op) == OP_SBC) ? c : 1'b0;
  assign sum       = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
  assign carry_msb = a[MSB] ^ opb[MSB] ^ sum[MSB];

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op_e'(op))
      OP_NOTA: alu_res = ~a;
      OP_NOTB: alu_res = ~b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_XNOR: alu_res = ~(a ^ b);
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = carry_msb ^ sum[WIDTH];
      end
      OP_SHL: begin
        alu_res = {a[MSB-1:0], 1'b0};
        alu_c   = a[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[MSB:1]};
        alu_c   = a[0];
      end
      OP_ASR: begin
        alu_res = {a[MSB], a[MSB:1]};
        alu_c   = a[0];
      end
      OP_PASS: alu_res = a;
      OP_MUL, OP_RSVD: alu_res = '0;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (cnt == LAST_STEP) state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      c         <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b0;
      v         <= 1'b0;
      out_valid <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept && is_mul) begin
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          acc    <= '0;
          cnt    <= '0;
        end else if (accept) begin
          result    <= alu_res;
          c         <= alu_c;
          n         <= alu_res[MSB];
          z         <= (alu_res == '0);
          v         <= alu_v;
          out_valid <= 1'b1;
        end
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == LAST_STEP) begin
          result    <= acc_next[MSB:0];
          c         <= |acc_next[2*WIDTH-1:WIDTH];
          n         <= acc_next[MSB];
          z         <= (acc_next[MSB:0] == '0);
          v         <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_n_seq.sv
// Self-checking bench for alu_n_seq (WIDTH=8): directed cases plus random ops
// compared against an integer-arithmetic reference model.
module tb_alu_n_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   op;
  logic         out_valid, c, n, z, v;

  int n_vec = 0;
  int n_err = 0;
  int m_c   = 0;

  alu_n_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .result(result), .out_valid(out_valid),
    .c(c), .n(n), .z(z), .v(v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: ops expressed as plain integer arithmetic on unsigned/signed values.
  task automatic model(input int mop, input int ma, input int mb,
                       output int res, output int mc, output int mv);
    int sa, sb, full, s;
    sa = (ma >= 128) ? ma - 256 : ma;
    sb = (mb >= 128) ? mb - 256 : mb;
    res = 0; mc = 0; mv = 0; full = 0; s = 0;
    case (mop)
      0:  res = 255 - ma;
      1:  res = 255 - mb;
      2:  res = ma & mb;
      3:  res = ma | mb;
      4:  res = ma ^ mb;
      5:  res = 255 - (ma ^ mb);
      6:  begin full = ma + mb;               s = sa + sb;            end
      7:  begin full = ma + (255 - mb) + 1;   s = sa - sb;            end
      8:  begin full = ma + mb + m_c;         s = sa + sb + m_c;      end
      9:  begin full = ma + (255 - mb) + m_c; s = sa - sb - 1 + m_c; end
      10: begin res = (ma * 2) % 256; mc = ma / 128; end
      11: begin res = ma / 2; mc = ma % 2; end
      12: begin res = ma / 2 + (ma & 128); mc = ma % 2; end
      13: begin full = ma * mb; res = full % 256; mc = (full / 256 != 0) ? 1 : 0; end
      14: res = ma;
      default: res = 0;
    endcase
    if (mop >= 6 && mop <= 9) begin
      res = full % 256;
      mc  = full / 256;
      mv  = (s > 127 || s < -128) ? 1 : 0;
    end
  endtask

  task automatic expect_done(input string tag, input int res, input int mc, input int mv);
    logic [3:0] ef;
    ef = {mc[0], res[7], (res == 0), mv[0]};
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, result, res);
    check({tag, "_cnzv"}, {c, n, z, v}, ef);
    m_c = mc;
  endtask

  // Called #1 after a rising edge; leaves time at #1 after the completion edge.
  task automatic run_op(input string tag, input int mop, input int ma, input int mb);
    int res, mc, mv;
    check({tag, "_ready"}, in_ready, 1);
    a = ma[W-1:0]; b = mb[W-1:0]; op = mop[3:0]; in_valid = 1'b1;
    @(posedge clk); #1;
    if (mop == 13) begin
      // in_valid stays high with a different op while busy; it must be ignored
      a = 8'hFF; b = 8'hFF; op = 4'h6;
      for (int j = 0; j < W; j++) begin
        check({tag, "_busy_ready"}, in_ready, 0);
        check({tag, "_busy_valid"}, out_valid, 0);
        @(posedge clk); #1;
      end
      check({tag, "_ready_back"}, in_ready, 1);
    end
    in_valid = 1'b0;
    model(mop, ma, mb, res, mc, mv);
    expect_done(tag, res, mc, mv);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    #12;
    check("rst_result", result, 0);
    check("rst_cnzv", {c, n, z, v}, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_7f_01", 6, 8'h7F, 8'h01);
    run_op("sub_05_05", 7, 8'h05, 8'h05);
    run_op("sub_00_01", 7, 8'h00, 8'h01);
    run_op("add_ff_01", 6, 8'hFF, 8'h01);
    run_op("adc_c1", 8, 8'h00, 8'h00);
    run_op("adc_c0", 8, 8'h00, 8'h00);
    @(posedge clk); #1;
    check("idle_no_valid", out_valid, 0);
    check("idle_hold_result", result, 0);
    run_op("mul_10_11", 13, 8'h10, 8'h11);
    run_op("shr_81", 11, 8'h81, 8'h00);
    run_op("asr_81", 12, 8'h81, 8'h00);
    run_op("shl_81", 10, 8'h81, 8'h00);
    run_op("sbc_80_01", 9, 8'h80, 8'h01);
    run_op("rsvd", 15, 8'h55, 8'hAA);

    // Reset after three multiply steps aborts the op
    a = 8'h10; b = 8'h11; op = 4'hD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mrst_result", result, 0);
    check("mrst_cnzv", {c, n, z, v}, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_ready", in_ready, 1);
    m_c = 0;
    @(negedge clk) reset = 1'b0;
    for (int j = 0; j < W + 2; j++) begin
      @(posedge clk); #1;
      check("mrst_no_pulse", out_valid, 0);
    end
    run_op("post_rst_adc", 8, 8'h01, 8'h02);

    for (int i = 0; i < 300; i++) begin
      int mop;
      mop = ($urandom_range(0, 7) == 0) ? 13 : int'($urandom_range(0, 15));
      run_op("rnd", mop, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        check("rnd_idle", out_valid, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
